// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM controller: FSM state encodings, default
// parameter values and a beat-index width helper.
package sram_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_DONE   = 2'd2;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_SRAM_DQ_W   = 16;
   localparam int DEF_SRAM_ADDR_W = 18;
   localparam int DEF_WAIT_CYCLES = 1;
   localparam int DEF_BASE_ADDR   = 1024;

   // A single-beat configuration still needs a 1-bit index register.
   function automatic int beat_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat sequencer: holds each SRAM beat for WAIT_CYCLES+1 cycles and walks the
// beat index from 0 to BEATS-1 while run is high.
module sram_beat_timer
   import sram_ctrl_pkg::*;
#(
   parameter int BEATS       = 2,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   localparam int BEAT_W     = beat_w(BEATS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [BEAT_W-1:0] beat,
   output logic              last_cycle_of_beat,
   output logic              last_beat
);

   logic [3:0] wait_cnt;

   assign last_cycle_of_beat = run && (wait_cnt == 4'(WAIT_CYCLES));
   assign last_beat          = (beat == BEAT_W'(BEATS - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         beat     <= '0;
      end else if (!run) begin
         wait_cnt <= '0;
         beat     <= '0;
      end else if (last_cycle_of_beat) begin
         wait_cnt <= '0;
         beat     <= last_beat ? '0 : beat + 1'b1;
      end else begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// Pipeline-to-SRAM bridge: splits each DATA_W access into SRAM_DQ_W beats.
// Optional one-entry read buffer compiled in with macro SRAM_RD_BUF_EN.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SRAM_DQ_W   = DEF_SRAM_DQ_W,
   parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   MEM_R_EN,
   input  logic                   MEM_W_EN,
   input  logic [31:0]            address,
   input  logic [DATA_W-1:0]      writeData,
   output logic [DATA_W-1:0]      readData,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic [SRAM_DQ_W-1:0]   SRAM_DQ_OUT,
   output logic                   SRAM_DQ_OE,
   input  logic [SRAM_DQ_W-1:0]   SRAM_DQ_IN,
   output logic                   SRAM_WE_N
);

   localparam int BEATS  = DATA_W / SRAM_DQ_W;
   localparam int BEAT_W = beat_w(BEATS);

   state_t              state;
   logic                op_write;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rd_shadow;
   logic [DATA_W-1:0]   rd_next;
   logic [DATA_W-1:0]   wdata_shift;
   logic [BEAT_W-1:0]   beat;
   logic                last_cycle;
   logic                last_beat;
   logic                req;
   logic                buf_hit;
   logic [31:0]         word_addr;

   assign req       = MEM_R_EN | MEM_W_EN;
   assign word_addr = (address - 32'(BASE_ADDR)) >> 2;
   assign ready     = (state == ST_DONE) || ((state == ST_IDLE) && !req);

   sram_beat_timer #(
      .BEATS       (BEATS),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_timer (
      .clk                (clk),
      .reset              (reset),
      .run                (state == ST_ACCESS),
      .beat               (beat),
      .last_cycle_of_beat (last_cycle),
      .last_beat          (last_beat)
   );

   // NOTE: every always_comb output gets a full default first, so no path
   // can leave it unassigned and infer a latch.
   always_comb begin
      rd_next = rd_shadow;
      rd_next[int'(beat) * SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ_IN;
      wdata_shift = wdata_q >> ((int'(beat) + 1) * SRAM_DQ_W);
   end

`ifdef SRAM_RD_BUF_EN
   logic              buf_valid;
   logic [31:0]       buf_tag;
   logic [31:0]       word_q;
   logic [DATA_W-1:0] buf_data;

   assign buf_hit = buf_valid && MEM_R_EN && !MEM_W_EN && (buf_tag == word_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         buf_valid <= 1'b0;
      else if ((state == ST_ACCESS) && last_cycle && last_beat && !op_write)
         buf_valid <= 1'b1;
   end

   // NOTE: tag, data and latched word are only consulted through buf_valid,
   // so this storage is left without reset.
   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && req && !buf_hit)
         word_q <= word_addr;
      if ((state == ST_ACCESS) && last_cycle && last_beat) begin
         if (!op_write) begin
            buf_tag  <= word_q;
            buf_data <= rd_next;
         end else if (buf_valid && (buf_tag == word_q)) begin
            buf_data <= wdata_q;
         end
      end
   end
`else
   assign buf_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_write    <= 1'b0;
         wdata_q     <= '0;
         rd_shadow   <= '0;
         readData    <= '0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_OUT <= '0;
         SRAM_WE_N   <= 1'b1;
         SRAM_DQ_OE  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (buf_hit) begin
                  state <= ST_DONE;
`ifdef SRAM_RD_BUF_EN
                  readData <= buf_data;
`endif
               end else if (req) begin
                  // A simultaneous read and write request is treated as a write.
                  state       <= ST_ACCESS;
                  op_write    <= MEM_W_EN;
                  wdata_q     <= writeData;
                  SRAM_ADDR   <= SRAM_ADDR_W'(word_addr * BEATS);
                  SRAM_DQ_OUT <= writeData[SRAM_DQ_W-1:0];
                  SRAM_WE_N   <= !MEM_W_EN;
                  SRAM_DQ_OE  <= MEM_W_EN;
               end
            end
            ST_ACCESS: begin
               if (last_cycle) begin
                  if (!op_write) begin
                     rd_shadow <= rd_next;
                     if (last_beat)
                        readData <= rd_next;
                  end
                  if (last_beat) begin
                     state      <= ST_DONE;
                     SRAM_WE_N  <= 1'b1;
                     SRAM_DQ_OE <= 1'b0;
                  end else begin
                     SRAM_ADDR   <= SRAM_ADDR + 1'b1;
                     SRAM_DQ_OUT <= wdata_shift[SRAM_DQ_W-1:0];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default instance plus a zero-wait
// instance, each with a small behavioural SRAM.
module tb_sram_controller;

   logic        clk;
   logic        reset;

   logic        r_en_a, w_en_a, r_en_b, w_en_b;
   logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
   logic [31:0] rdata_a, rdata_b;
   logic        ready_a, ready_b;
   logic [17:0] sram_addr_a, sram_addr_b;
   logic [15:0] dq_out_a, dq_out_b, dq_in_a, dq_in_b;
   logic        oe_a, oe_b, we_n_a, we_n_b;

   logic [15:0] mem_a [0:15];
   logic [15:0] mem_b [0:15];

   logic [17:0] log_addr [0:19];
   logic [15:0] log_dq   [0:19];
   logic        log_we   [0:19];
   logic        log_oe   [0:19];

   int errors = 0;
   int checks = 0;
   int lat;

   sram_controller dut (
      .clk(clk), .reset(reset), .MEM_R_EN(r_en_a), .MEM_W_EN(w_en_a),
      .address(addr_a), .writeData(wdata_a), .readData(rdata_a), .ready(ready_a),
      .SRAM_ADDR(sram_addr_a), .SRAM_DQ_OUT(dq_out_a), .SRAM_DQ_OE(oe_a),
      .SRAM_DQ_IN(dq_in_a), .SRAM_WE_N(we_n_a)
   );

   sram_controller #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .MEM_R_EN(r_en_b), .MEM_W_EN(w_en_b),
      .address(addr_b), .writeData(wdata_b), .readData(rdata_b), .ready(ready_b),
      .SRAM_ADDR(sram_addr_b), .SRAM_DQ_OUT(dq_out_b), .SRAM_DQ_OE(oe_b),
      .SRAM_DQ_IN(dq_in_b), .SRAM_WE_N(we_n_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dq_in_a = mem_a[sram_addr_a[3:0]];
   assign dq_in_b = mem_b[sram_addr_b[3:0]];

   // Asynchronous SRAM model; reset also seeds a few known words.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_a[9] <= 16'h0BAD;
         mem_b[2] <= 16'hC0DE;
         mem_b[3] <= 16'hFACE;
      end else begin
         if (!we_n_a) mem_a[sram_addr_a[3:0]] <= dq_out_a;
         if (!we_n_b) mem_b[sram_addr_b[3:0]] <= dq_out_b;
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Issue one request (held for the request cycle only), log the SRAM pins
   // each following cycle and return the cycle number at which ready rises.
   task automatic run_txn(input bit sel, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int latency);
      @(negedge clk);
      if (sel) begin
         r_en_b = rd; w_en_b = wr; addr_b = addr; wdata_b = data;
      end else begin
         r_en_a = rd; w_en_a = wr; addr_a = addr; wdata_a = data;
      end
      #1;
      check("ready_low_in_request_cycle", sel ? ready_b : ready_a, 0);
      latency = 20;
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         log_addr[k] = sel ? sram_addr_b : sram_addr_a;
         log_dq[k]   = sel ? dq_out_b : dq_out_a;
         log_we[k]   = sel ? we_n_b : we_n_a;
         log_oe[k]   = sel ? oe_b : oe_a;
         r_en_a = 0; w_en_a = 0; r_en_b = 0; w_en_b = 0;
         if (sel ? ready_b : ready_a) begin
            latency = k;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      r_en_a = 0; w_en_a = 0; addr_a = '0; wdata_a = '0;
      r_en_b = 0; w_en_b = 0; addr_b = '0; wdata_b = '0;
      repeat (2) @(negedge clk);

      check("rst_ready", ready_a, 1);
      check("rst_we_n", we_n_a, 1);
      check("rst_oe", oe_a, 0);
      check("rst_sram_addr", sram_addr_a, 0);
      check("rst_read_data", rdata_a, 0);
      check("rst_dq_out", dq_out_a, 0);
      reset = 1'b0;
      @(negedge clk);

      // Write 0xDEADBEEF to byte 1024: SRAM words 0 and 1, two cycles each.
      run_txn(0, 1, 0, 32'd1024, 32'hDEADBEEF, lat);
      check("wr_latency", lat, 5);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("wr_addr_c%0d", k), log_addr[k], (k < 3) ? 0 : 1);
         check($sformatf("wr_dq_c%0d", k), log_dq[k], (k < 3) ? 16'hBEEF : 16'hDEAD);
         check($sformatf("wr_we_n_c%0d", k), log_we[k], 0);
         check($sformatf("wr_oe_c%0d", k), log_oe[k], 1);
      end
      check("wr_done_we_n", log_we[5], 1);
      check("wr_done_oe", log_oe[5], 0);
      check("wr_mem0", mem_a[0], 16'hBEEF);
      check("wr_mem1", mem_a[1], 16'hDEAD);

      // Read back the same word.
      run_txn(0, 0, 1, 32'd1024, 32'h0, lat);
      check("rd_latency", lat, 5);
      check("rd_data", rdata_a, 32'hDEADBEEF);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("rd_addr_c%0d", k), log_addr[k], (k < 3) ? 0 : 1);
         check($sformatf("rd_we_n_c%0d", k), log_we[k], 1);
         check($sformatf("rd_oe_c%0d", k), log_oe[k], 0);
      end

      // Zero-wait instance: byte 1028 -> SRAM words 2,3 one cycle each.
      run_txn(1, 0, 1, 32'd1028, 32'h0, lat);
      check("w0_latency", lat, 3);
      check("w0_addr_c1", log_addr[1], 2);
      check("w0_addr_c2", log_addr[2], 3);
      check("w0_read_data", rdata_b, 32'hFACEC0DE);

      // Both enables high is a write; readData keeps the previous load.
      run_txn(0, 1, 1, 32'd1032, 32'h12345678, lat);
      check("both_latency", lat, 5);
      check("both_we_n_c1", log_we[1], 0);
      check("both_mem4", mem_a[4], 16'h5678);
      check("both_mem5", mem_a[5], 16'h1234);
      check("both_read_data_held", rdata_a, 32'hDEADBEEF);

      // Back in IDLE with no request: address holds, strobes inactive.
      @(negedge clk);
      check("idle_ready", ready_a, 1);
      check("idle_addr_hold", sram_addr_a, 5);
      check("idle_we_n", we_n_a, 1);
      check("idle_oe", oe_a, 0);

      // Reset in the second cycle of the first write beat to byte 1040.
      @(negedge clk);
      w_en_a = 1; addr_a = 32'd1040; wdata_a = 32'hCAFEF00D;
      @(negedge clk);
      w_en_a = 0;
      @(negedge clk);
      check("abort_pre_addr", sram_addr_a, 8);
      check("abort_pre_we_n", we_n_a, 0);
      reset = 1'b1;
      #1;
      check("abort_we_n", we_n_a, 1);
      check("abort_oe", oe_a, 0);
      @(negedge clk);
      check("abort_ready", ready_a, 1);
      check("abort_addr", sram_addr_a, 0);
      check("abort_read_data", rdata_a, 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_mem8", mem_a[8], 16'hF00D);
      check("abort_mem9_untouched", mem_a[9], 16'h0BAD);

`ifdef SRAM_RD_BUF_EN
      run_txn(0, 0, 1, 32'd1024, 32'h0, lat);
      check("buf_miss_latency", lat, 5);
      check("buf_miss_data", rdata_a, 32'hDEADBEEF);
      run_txn(0, 0, 1, 32'd1024, 32'h0, lat);
      check("buf_hit_latency", lat, 1);
      check("buf_hit_addr_hold", log_addr[1], 1);
      check("buf_hit_we_n", log_we[1], 1);
      check("buf_hit_data", rdata_a, 32'hDEADBEEF);
      run_txn(0, 1, 0, 32'd1024, 32'h1, lat);
      check("buf_wr_latency", lat, 5);
      run_txn(0, 0, 1, 32'd1024, 32'h0, lat);
      check("buf_upd_latency", lat, 1);
      check("buf_upd_data", rdata_a, 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
